// File: rtl/dft64_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dft64_frame_sequencer
//  Description : Frame-level controller for the 64-point DFT engine. Gathers
//                64 real samples into an 8x8 buffer, clears the engine,
//                releases the rows one per cycle, waits for completion plus
//                a drain interval, then streams 64 complex bins row-major.
//  Revision    : 1.0  initial release
// ============================================================================
module dft64_frame_sequencer #(
   parameter int DATA_W         = 16,
   parameter int DRAIN_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   clk,
   input  logic                   sreset,
   // sample input stream
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_sample,
   // engine control
   output logic                   dft_clear,
   output logic                   dft_rel,
   output logic                   dft_calculate,
   output logic [8*DATA_W-1:0]    dft_samples,
   input  logic                   dft_done,
   input  logic [64*DATA_W-1:0]   dft_real,
   input  logic [64*DATA_W-1:0]   dft_imag,
   // bin output stream
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_real,
   output logic [DATA_W-1:0]      out_imag,
   output logic [5:0]             out_index,
   // status
   output logic                   frame_done,
   output logic                   timeout_err,
   output logic                   busy
);

   // Counter widths; a one-cycle interval still needs a 1-bit counter.
   localparam int WAIT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int DRAIN_W = (DRAIN_CYCLES   > 1) ? $clog2(DRAIN_CYCLES)   : 1;
   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CLEAR  = 3'd2,
      S_ISSUE  = 3'd3,
      S_WAIT   = 3'd4,
      S_DRAIN  = 3'd5,
      S_UNLOAD = 3'd6
   } state_t;

   state_t                 state_q;
   logic [5:0]             load_cnt_q;
   logic [2:0]             issue_row_q;
   logic [WAIT_W-1:0]      wait_cnt_q;
   logic [DRAIN_W-1:0]     drain_cnt_q;
   logic [5:0]             out_idx_q;
   logic                   done_seen_q;

   logic                   in_ready_q;
   logic                   dft_clear_q;
   logic                   dft_rel_q;
   logic                   dft_calc_q;
   logic [8*DATA_W-1:0]    dft_samples_q;
   logic                   out_valid_q;
   logic                   frame_done_q;
   logic                   timeout_err_q;
   logic                   busy_q;

   // Sample storage, flat index = row*8 + lane (contents need no reset)
   logic [DATA_W-1:0]      smp_buf_q [0:63];

   logic                   in_fire;
   logic                   out_fire;
   logic [2:0]             row_sel_d;
   logic [8*DATA_W-1:0]    samples_d;

   // in_ready_q is only high in IDLE/LOAD, so a fire always belongs to a load
   assign in_fire  = in_valid  & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   // Store each accepted sample; load_cnt_q is 0 whenever the FSM is in IDLE
   always_ff @(posedge clk) begin
      if (in_fire) begin
         smp_buf_q[load_cnt_q] <= in_sample;
      end
   end

   // Assemble the row to present on the next cycle: row 0 on ISSUE entry,
   // otherwise the row following the one currently presented
   always_comb begin
      row_sel_d = (state_q == S_ISSUE) ? (issue_row_q + 3'd1) : 3'd0;
      samples_d = '0;
      for (int j = 0; j < 8; j++) begin
         samples_d[j*DATA_W +: DATA_W] = smp_buf_q[{row_sel_d, 3'(j)}];
      end
   end

   // Frame sequencing FSM; every control output is registered alongside state
   always_ff @(posedge clk or posedge sreset) begin
      if (sreset) begin
         state_q       <= S_IDLE;
         load_cnt_q    <= '0;
         issue_row_q   <= '0;
         wait_cnt_q    <= '0;
         drain_cnt_q   <= '0;
         out_idx_q     <= '0;
         done_seen_q   <= 1'b0;
         in_ready_q    <= 1'b1;
         dft_clear_q   <= 1'b0;
         dft_rel_q     <= 1'b0;
         dft_calc_q    <= 1'b0;
         dft_samples_q <= '0;
         out_valid_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         // single-cycle strobes
         dft_clear_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (in_fire) begin
                  state_q    <= S_LOAD;
                  load_cnt_q <= 6'd1;
                  busy_q     <= 1'b1;
               end
            end

            S_LOAD: begin
               if (in_fire) begin
                  // wraps back to 0 after the 64th sample, ready for next frame
                  load_cnt_q <= load_cnt_q + 6'd1;
                  if (load_cnt_q == 6'd63) begin
                     state_q     <= S_CLEAR;
                     in_ready_q  <= 1'b0;
                     dft_clear_q <= 1'b1;
                  end
               end
            end

            S_CLEAR: begin
               state_q       <= S_ISSUE;
               dft_rel_q     <= 1'b1;
               dft_calc_q    <= 1'b1;
               dft_samples_q <= samples_d;
               issue_row_q   <= 3'd0;
               done_seen_q   <= 1'b0;
            end

            S_ISSUE: begin
               if (issue_row_q == 3'd7) begin
                  dft_rel_q     <= 1'b0;
                  dft_samples_q <= '0;
                  issue_row_q   <= 3'd0;
                  done_seen_q   <= 1'b0;
                  // a done already seen (or arriving now) skips WAIT entirely
                  if (done_seen_q || dft_done) begin
                     state_q     <= S_DRAIN;
                     drain_cnt_q <= '0;
                  end else begin
                     state_q    <= S_WAIT;
                     wait_cnt_q <= '0;
                  end
               end else begin
                  issue_row_q   <= issue_row_q + 3'd1;
                  dft_samples_q <= samples_d;
                  done_seen_q   <= done_seen_q | dft_done;
               end
            end

            S_WAIT: begin
               if (dft_done) begin
                  state_q     <= S_DRAIN;
                  drain_cnt_q <= '0;
                  wait_cnt_q  <= '0;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  // engine never answered: abandon the frame
                  state_q       <= S_IDLE;
                  wait_cnt_q    <= '0;
                  timeout_err_q <= 1'b1;
                  dft_calc_q    <= 1'b0;
                  in_ready_q    <= 1'b1;
                  busy_q        <= 1'b0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end

            S_DRAIN: begin
               if (drain_cnt_q == DRAIN_LAST) begin
                  state_q     <= S_UNLOAD;
                  drain_cnt_q <= '0;
                  dft_calc_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_idx_q   <= 6'd0;
               end else begin
                  drain_cnt_q <= drain_cnt_q + 1'b1;
               end
            end

            S_UNLOAD: begin
               if (out_fire) begin
                  if (out_idx_q == 6'd63) begin
                     state_q      <= S_IDLE;
                     out_valid_q  <= 1'b0;
                     out_idx_q    <= 6'd0;
                     frame_done_q <= 1'b1;
                     in_ready_q   <= 1'b1;
                     busy_q       <= 1'b0;
                  end else begin
                     out_idx_q <= out_idx_q + 6'd1;
                  end
               end
            end

            default: begin
               state_q       <= S_IDLE;
               load_cnt_q    <= '0;
               issue_row_q   <= '0;
               wait_cnt_q    <= '0;
               drain_cnt_q   <= '0;
               out_idx_q     <= '0;
               done_seen_q   <= 1'b0;
               in_ready_q    <= 1'b1;
               dft_rel_q     <= 1'b0;
               dft_calc_q    <= 1'b0;
               dft_samples_q <= '0;
               out_valid_q   <= 1'b0;
               busy_q        <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready      = in_ready_q;
   assign dft_clear     = dft_clear_q;
   assign dft_rel       = dft_rel_q;
   assign dft_calculate = dft_calc_q;
   assign dft_samples   = dft_samples_q;
   assign out_valid     = out_valid_q;
   assign frame_done    = frame_done_q;
   assign timeout_err   = timeout_err_q;
   assign busy          = busy_q;

   // Bin mux is combinational; gated so the data lanes read 0 outside UNLOAD
   assign out_index = out_idx_q;
   assign out_real  = out_valid_q ? dft_real[int'(out_idx_q)*DATA_W +: DATA_W] : '0;
   assign out_imag  = out_valid_q ? dft_imag[int'(out_idx_q)*DATA_W +: DATA_W] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dft64_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dft64_frame_sequencer
//  Description : Self-checking bench for dft64_frame_sequencer with a stub
//                engine and a scoreboard of expected rows and bins.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dft64_frame_sequencer;

   localparam int DW    = 16;
   localparam int DRAIN = 4;
   localparam int TMO   = 16;

   logic              clk = 1'b0;
   logic              sreset;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_sample;
   logic              dft_clear;
   logic              dft_rel;
   logic              dft_calculate;
   logic [8*DW-1:0]   dft_samples;
   logic              dft_done;
   logic [64*DW-1:0]  dft_real;
   logic [64*DW-1:0]  dft_imag;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_real;
   logic [DW-1:0]     out_imag;
   logic [5:0]        out_index;
   logic              frame_done;
   logic              timeout_err;
   logic              busy;

   int total = 0;
   int bad   = 0;

   logic [8*DW-1:0]   row_q[$];   // expected rows, in release order
   logic [2*DW+5:0]   bin_q[$];   // expected {index, real, imag}

   always #5 clk = ~clk;

   dft64_frame_sequencer #(
      .DATA_W         (DW),
      .DRAIN_CYCLES   (DRAIN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .sreset        (sreset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sample     (in_sample),
      .dft_clear     (dft_clear),
      .dft_rel       (dft_rel),
      .dft_calculate (dft_calculate),
      .dft_samples   (dft_samples),
      .dft_done      (dft_done),
      .dft_real      (dft_real),
      .dft_imag      (dft_imag),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_real      (out_real),
      .out_imag      (out_imag),
      .out_index     (out_index),
      .frame_done    (frame_done),
      .timeout_err   (timeout_err),
      .busy          (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // stub engine result: bin k holds real=k+seed, imag=-(k+seed)
   task automatic set_bins(input int seed);
      for (int k = 0; k < 64; k++) begin
         dft_real[k*DW +: DW] = DW'(k + seed);
         dft_imag[k*DW +: DW] = DW'(-(k + seed));
      end
   endtask

   task automatic push_bins(input int seed);
      for (int k = 0; k < 64; k++) begin
         bin_q.push_back({6'(k), DW'(k + seed), DW'(-(k + seed))});
      end
   endtask

   // feed samples base..base+63; gaps insert an idle cycle (with a stray done)
   task automatic load_frame(input int base, input bit gaps);
      logic [8*DW-1:0] row;
      row = '0;
      for (int i = 0; i < 64; i++) begin
         if (gaps && (i % 2 == 1)) begin
            in_valid = 1'b0;
            dft_done = 1'b1;
            tick();
            dft_done = 1'b0;
         end
         in_valid  = 1'b1;
         in_sample = DW'(base + i);
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_ready[%0d]: got %b want 1", i, in_ready);
         end
         row[(i % 8)*DW +: DW] = DW'(base + i);
         if (i % 8 == 7) row_q.push_back(row);
         tick();
      end
      in_valid = 1'b0;
      total++;
      if ({in_ready, dft_clear, busy, dft_rel} !== 4'b0110) begin
         bad++;
         $display("FAIL load_end: ready/clear/busy/rel got %b%b%b%b want 0110",
                  in_ready, dft_clear, busy, dft_rel);
      end
   endtask

   // entered in the CLEAR cycle; returns early in row stop_row if < 8
   task automatic issue_phase(input bit done_last, input int stop_row);
      logic [8*DW-1:0] exp_row;
      tick();
      for (int r = 0; r < 8; r++) begin
         if (r == stop_row) return;
         exp_row = '0;
         total++;
         if (row_q.size() == 0) begin
            bad++;
            $display("FAIL issue_row[%0d]: no expected row queued", r);
         end else begin
            exp_row = row_q.pop_front();
            if (dft_samples !== exp_row) begin
               bad++;
               $display("FAIL issue_row[%0d]: got %h want %h", r, dft_samples, exp_row);
            end
         end
         total++;
         if ({dft_rel, dft_calculate, dft_clear, in_ready} !== 4'b1100) begin
            bad++;
            $display("FAIL issue_ctl[%0d]: rel/calc/clear/ready got %b%b%b%b want 1100",
                     r, dft_rel, dft_calculate, dft_clear, in_ready);
         end
         if (r == 7 && done_last) dft_done = 1'b1;
         tick();
      end
      dft_done = 1'b0;
      total++;
      if ({dft_rel, dft_calculate} !== 2'b01) begin
         bad++;
         $display("FAIL issue_after: rel/calc got %b%b want 01", dft_rel, dft_calculate);
      end
   endtask

   // done arrives d cycles after the last release (d=0: coincident)
   task automatic engine_and_drain(input int d, input int seed);
      set_bins(seed);
      push_bins(seed);
      if (d > 0) begin
         for (int k = 1; k < d; k++) begin
            total++;
            if ({dft_calculate, out_valid, busy} !== 3'b101) begin
               bad++;
               $display("FAIL wait_ctl[%0d]: calc/valid/busy got %b%b%b want 101",
                        k, dft_calculate, out_valid, busy);
            end
            tick();
         end
         dft_done = 1'b1;
         tick();
         dft_done = 1'b0;
      end
      for (int k = 0; k < DRAIN; k++) begin
         total++;
         if ({out_valid, dft_calculate} !== 2'b01) begin
            bad++;
            $display("FAIL drain[%0d]: valid/calc got %b%b want 01", k, out_valid, dft_calculate);
         end
         tick();
      end
      total++;
      if ({out_valid, dft_calculate, out_index} !== {2'b10, 6'd0}) begin
         bad++;
         $display("FAIL unload_entry: valid/calc/index got %b%b/%0d want 10/0",
                  out_valid, dft_calculate, out_index);
      end
   endtask

   // drain the bin stream, optionally with random backpressure
   task automatic unload(input bit bp);
      int              hs;
      int              cyc;
      bit              stalled;
      logic [2*DW+5:0] held;
      logic [2*DW+5:0] exp_bin;
      hs = 0; cyc = 0; stalled = 1'b0; held = '0;
      while (hs < 64 && cyc < 1000) begin
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid) begin
            if (stalled) begin
               total++;
               if ({out_index, out_real, out_imag} !== held) begin
                  bad++;
                  $display("FAIL bin_hold: got %h want %h", {out_index, out_real, out_imag}, held);
               end
            end
            if (out_ready) begin
               total++;
               if (bin_q.size() == 0) begin
                  bad++;
                  $display("FAIL bin: got %h want nothing queued", {out_index, out_real, out_imag});
               end else begin
                  exp_bin = bin_q.pop_front();
                  if ({out_index, out_real, out_imag} !== exp_bin) begin
                     bad++;
                     $display("FAIL bin[%0d]: got %h want %h", hs,
                              {out_index, out_real, out_imag}, exp_bin);
                  end
               end
               hs++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = {out_index, out_real, out_imag};
            end
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      total++;
      if (hs != 64 || bin_q.size() != 0) begin
         bad++;
         $display("FAIL unload_count: got %0d handshakes (%0d left) want 64 (0 left)", hs, bin_q.size());
      end
      total++;
      if ({frame_done, busy, out_valid, in_ready} !== 4'b1001) begin
         bad++;
         $display("FAIL frame_end: done/busy/valid/ready got %b%b%b%b want 1001",
                  frame_done, busy, out_valid, in_ready);
      end
      tick();
      total++;
      if ({frame_done, out_valid} !== 2'b00) begin
         bad++;
         $display("FAIL frame_done_pulse: done/valid got %b%b want 00", frame_done, out_valid);
      end
   endtask

   task automatic test_reset();
      sreset    = 1'b1;
      in_valid  = 1'b0;
      in_sample = '0;
      out_ready = 1'b0;
      dft_done  = 1'b0;
      set_bins(1);
      tick();
      tick();
      total++;
      if ({in_ready, dft_clear, dft_rel, dft_calculate, out_valid, frame_done, timeout_err, busy}
          !== 8'b1000_0000 || dft_samples !== '0 || out_real !== '0 || out_imag !== '0
          || out_index !== 6'd0) begin
         bad++;
         $display("FAIL reset_state: ctl=%b%b%b%b%b%b%b%b real=%h idx=%0d want 10000000 0 0",
                  in_ready, dft_clear, dft_rel, dft_calculate, out_valid, frame_done,
                  timeout_err, busy, out_real, out_index);
      end
      sreset = 1'b0;
      tick();
      total++;
      if ({in_ready, busy} !== 2'b10) begin
         bad++;
         $display("FAIL reset_release: ready/busy got %b%b want 10", in_ready, busy);
      end
   endtask

   task automatic test_frame();
      load_frame(0, 1'b0);
      issue_phase(1'b0, 8);
      engine_and_drain(3, 0);
      unload(1'b0);
   endtask

   task automatic test_backpressure();
      load_frame(0, 1'b1);
      issue_phase(1'b1, 8);
      engine_and_drain(0, 100);
      unload(1'b1);
   endtask

   task automatic test_timeout();
      load_frame(200, 1'b0);
      issue_phase(1'b0, 8);
      for (int k = 0; k < TMO; k++) begin
         total++;
         if ({timeout_err, dft_calculate, busy} !== 3'b011) begin
            bad++;
            $display("FAIL timeout_wait[%0d]: err/calc/busy got %b%b%b want 011",
                     k, timeout_err, dft_calculate, busy);
         end
         tick();
      end
      total++;
      if ({timeout_err, in_ready, busy, out_valid, dft_calculate} !== 5'b11000) begin
         bad++;
         $display("FAIL timeout_fire: err/ready/busy/valid/calc got %b%b%b%b%b want 11000",
                  timeout_err, in_ready, busy, out_valid, dft_calculate);
      end
      tick();
      total++;
      if ({timeout_err, out_valid, in_ready} !== 3'b001) begin
         bad++;
         $display("FAIL timeout_pulse: err/valid/ready got %b%b%b want 001",
                  timeout_err, out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_issue();
      set_bins(7);
      load_frame(300, 1'b0);
      issue_phase(1'b0, 4);
      sreset = 1'b1;
      #1;
      total++;
      if ({in_ready, dft_clear, dft_rel, dft_calculate, out_valid, frame_done, timeout_err, busy}
          !== 8'b1000_0000 || dft_samples !== '0 || out_real !== '0 || out_imag !== '0
          || out_index !== 6'd0) begin
         bad++;
         $display("FAIL async_reset: ctl=%b%b%b%b%b%b%b%b samples=%h want 10000000 0",
                  in_ready, dft_clear, dft_rel, dft_calculate, out_valid, frame_done,
                  timeout_err, busy, dft_samples);
      end
      tick();
      tick();
      sreset = 1'b0;
      row_q.delete();
      tick();
      total++;
      if ({in_ready, busy, frame_done, timeout_err} !== 4'b1000) begin
         bad++;
         $display("FAIL post_reset: ready/busy/done/err got %b%b%b%b want 1000",
                  in_ready, busy, frame_done, timeout_err);
      end
      load_frame(500, 1'b0);
      issue_phase(1'b0, 8);
      engine_and_drain(5, 40);
      unload(1'b1);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_backpressure();
      test_timeout();
      test_reset_mid_issue();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
